sealed_batch_counter: RTL and testbench

//   Parametrised successor of the sealed-bottle counter on the bottling line.

---
 rtl/bottling_pkg.sv | 12 +
 rtl/sensor_debounce.sv | 66 ++++++
 rtl/sealed_batch_counter.sv | 149 ++++++++++++++
 tb/tb_sealed_batch_counter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bottling_pkg.sv
// Shared types and default constants for the bottling-line counters.
package bottling_pkg;

  typedef enum logic {
    COUNT = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int DEFAULT_BATCH_SIZE      = 65;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/sensor_debounce.sv
// Synchronises the raw capper sensor, debounces it and emits a one-cycle pulse
// on each rising edge of the filtered level.
module sensor_debounce
  import bottling_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] RUN_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("sensor_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] run;
  logic          differs;
  logic          settle;

  assign differs = (sync_b != level_out);
  assign settle  = differs && (run == RUN_LAST);

  // NOTE: sequential state uses <= so each flop samples pre-edge values; with =
  // the two synchroniser stages would collapse into one.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw_in;
      sync_b <= sync_a;
    end
  end

  // Any sample matching the filtered level restarts the stability run.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run <= '0;
    end else if (!differs || settle) begin
      run <= '0;
    end else begin
      run <= run + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      if (settle) begin
        level_out <= sync_b;
      end
      rise_pulse <= settle && sync_b;
    end
  end

endmodule

// File: rtl/sealed_batch_counter.sv
// Counts filtered sealed-bottle pulses into batches of BATCH_SIZE, holds a full
// batch until the packer acks it, and tracks completed batches and lost bottles.
module sealed_batch_counter
  import bottling_pkg::*;
#(
  parameter int WIDTH           = 7,
  parameter int BATCH_SIZE      = DEFAULT_BATCH_SIZE,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int BATCH_W         = 8,
  parameter int MISS_W          = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               sealed_in,
  input  logic               en,
  input  logic               clear,
  input  logic               batch_ack,
  output logic [WIDTH-1:0]   count,
  output logic               batch_done,
  output logic [BATCH_W-1:0] batch_total,
  output logic [MISS_W-1:0]  missed,
  output logic               overrun
);

  localparam logic [WIDTH-1:0] LAST_SLOT = WIDTH'(BATCH_SIZE - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  if (BATCH_SIZE < 1 || BATCH_SIZE > (2 ** WIDTH) - 1) begin : g_bad_batch_size
    $error("sealed_batch_counter: BATCH_SIZE must lie in 1 .. 2**WIDTH-1");
  end

  logic filtered_level;
  logic rise_pulse;
  logic bottle;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sensor_debounce (
    .CLK       (CLK),
    .RST       (RST),
    .raw_in    (sealed_in),
    .level_out (filtered_level),
    .rise_pulse(rise_pulse)
  );

  // The pulse is issued together with the new high level; requiring both keeps
  // the counted event tied to a filtered level that really is high.
  assign bottle = rise_pulse && filtered_level && en;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0]   count_next;
  logic               batch_done_next;
  logic [BATCH_W-1:0] batch_total_next;
  logic [MISS_W-1:0]  missed_next;
  logic               overrun_next;
  logic [BATCH_W-1:0] batch_total_inc;
  logic [MISS_W-1:0]  missed_inc;
  logic               completes_batch;

  assign batch_total_inc = (&batch_total) ? batch_total : batch_total + 1'b1;
  assign missed_inc      = (&missed) ? missed : missed + 1'b1;
  assign completes_batch = bottle && (count == LAST_SLOT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= COUNT;
    end else begin
      state <= state_next;
    end
  end

  // With BATCH_SIZE=1 a bottle arriving with the ack fills the new batch at once.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = COUNT;
    end else begin
      unique case (state)
        COUNT: if (completes_batch) state_next = FULL;
        FULL:  if (batch_ack && !(bottle && BATCH_SIZE == 1)) state_next = COUNT;
        default: state_next = COUNT;
      endcase
    end
  end

  // NOTE: every signal written here gets a default first, so no branch leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    count_next       = count;
    batch_done_next  = batch_done;
    batch_total_next = batch_total;
    missed_next      = missed;
    overrun_next     = overrun;
    if (clear) begin
      count_next       = '0;
      batch_done_next  = 1'b0;
      batch_total_next = '0;
      missed_next      = '0;
      overrun_next     = 1'b0;
    end else begin
      unique case (state)
        COUNT: begin
          if (bottle) begin
            count_next = count + 1'b1;
          end
          if (completes_batch) begin
            batch_done_next  = 1'b1;
            batch_total_next = batch_total_inc;
          end
        end
        FULL: begin
          if (batch_ack) begin
            count_next      = bottle ? ONE : '0;
            batch_done_next = 1'b0;
            if (bottle && BATCH_SIZE == 1) begin
              batch_done_next  = 1'b1;
              batch_total_next = batch_total_inc;
            end
          end else if (bottle) begin
            missed_next  = missed_inc;
            overrun_next = 1'b1;
          end
        end
        default: begin
          count_next = count;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count       <= '0;
      batch_done  <= 1'b0;
      batch_total <= '0;
      missed      <= '0;
      overrun     <= 1'b0;
    end else begin
      count       <= count_next;
      batch_done  <= batch_done_next;
      batch_total <= batch_total_next;
      missed      <= missed_next;
      overrun     <= overrun_next;
    end
  end

endmodule

// File: tb/tb_sealed_batch_counter.sv
// Scoreboard bench: stimulus drives bottles and pushes expected snapshots for a
// default counter and a narrow one; a monitor compares them on their due edge.
module tb_sealed_batch_counter;

  localparam int D   = 4;
  localparam int BS  = 65;
  localparam int BS2 = 2;
  localparam int LEN = 2 * D + 16;

  typedef struct {
    int count;
    int done;
    int total;
    int missed;
    int overrun;
  } model_t;

  typedef struct {
    int     due;
    string  tag;
    model_t a;
    model_t b;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic       sealed_in;
  logic       en;
  logic       clear;
  logic       batch_ack;
  logic [6:0] count;
  logic       batch_done;
  logic [7:0] batch_total;
  logic [3:0] missed;
  logic       overrun;
  logic [1:0] count2;
  logic       batch_done2;
  logic [1:0] batch_total2;
  logic [1:0] missed2;
  logic       overrun2;

  int     cyc = 0;
  int     total_checks = 0;
  int     bad_checks = 0;
  model_t ma;
  model_t mb;
  exp_t   sb[$];

  sealed_batch_counter dut (
    .CLK(CLK), .RST(RST), .sealed_in(sealed_in), .en(en), .clear(clear),
    .batch_ack(batch_ack), .count(count), .batch_done(batch_done),
    .batch_total(batch_total), .missed(missed), .overrun(overrun)
  );

  sealed_batch_counter #(
    .WIDTH(2), .BATCH_SIZE(BS2), .DEBOUNCE_CYCLES(D), .BATCH_W(2), .MISS_W(2)
  ) dut_narrow (
    .CLK(CLK), .RST(RST), .sealed_in(sealed_in), .en(en), .clear(clear),
    .batch_ack(batch_ack), .count(count2), .batch_done(batch_done2),
    .batch_total(batch_total2), .missed(missed2), .overrun(overrun2)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total_checks++;
    if (act != exp) begin
      bad_checks++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic model_t zero_model();
    model_t z;
    z = '{0, 0, 0, 0, 0};
    return z;
  endfunction

  // Batch rules: fill to bs, then hold; bottles while holding are lost unless acked.
  function automatic model_t step(model_t m, int bs, int bmax, int mmax,
                                  bit p, bit ack, bit clr);
    model_t r;
    r = m;
    if (clr) begin
      r = zero_model();
    end else if (r.done == 0) begin
      if (p) begin
        r.count = r.count + 1;
        if (r.count == bs) begin
          r.done  = 1;
          r.total = (r.total < bmax) ? r.total + 1 : bmax;
        end
      end
    end else if (ack) begin
      r.done  = 0;
      r.count = p ? 1 : 0;
      if (p && r.count == bs) begin
        r.done  = 1;
        r.total = (r.total < bmax) ? r.total + 1 : bmax;
      end
    end else if (p) begin
      r.missed  = (r.missed < mmax) ? r.missed + 1 : mmax;
      r.overrun = 1;
    end
    return r;
  endfunction

  task automatic apply(input bit p, input bit ack, input bit clr);
    ma = step(ma, BS, 255, 15, p, ack, clr);
    mb = step(mb, BS2, 3, 3, p, ack, clr);
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.due = cyc + 1;
    e.tag = tag;
    e.a   = ma;
    e.b   = mb;
    sb.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    check({e.tag, "_count"},    int'(count),        e.a.count);
    check({e.tag, "_done"},     int'(batch_done),   e.a.done);
    check({e.tag, "_total"},    int'(batch_total),  e.a.total);
    check({e.tag, "_missed"},   int'(missed),       e.a.missed);
    check({e.tag, "_overrun"},  int'(overrun),      e.a.overrun);
    check({e.tag, "_count2"},   int'(count2),       e.b.count);
    check({e.tag, "_done2"},    int'(batch_done2),  e.b.done);
    check({e.tag, "_total2"},   int'(batch_total2), e.b.total);
    check({e.tag, "_missed2"},  int'(missed2),      e.b.missed);
    check({e.tag, "_overrun2"}, int'(overrun2),     e.b.overrun);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due != cyc) check({e.tag, "_late"}, cyc, e.due);
        else compare(e);
      end
    end
  end

  // One bottle: sensor high for hlen cycles; the controls are applied in the
  // cycle the filtered pulse reaches the counter (edge D+2 after first sample).
  task automatic bottle(input int hlen, input bit en_v, input bit ack_v,
                        input bit clr_v, input string tag);
    @(negedge CLK);
    sealed_in = 1'b1;
    for (int i = 1; i < LEN; i++) begin
      @(negedge CLK);
      sealed_in = (i < hlen);
      en        = 1'b1;
      batch_ack = 1'b0;
      clear     = 1'b0;
      if (i == D + 1) push({tag, "_pre"});
      if (i == D + 2) begin
        en        = en_v;
        batch_ack = ack_v;
        clear     = clr_v;
        apply((hlen >= D) && en_v, ack_v, clr_v);
        push({tag, "_post"});
      end
    end
  endtask

  task automatic ctrl(input bit ack_v, input bit clr_v, input string tag);
    @(negedge CLK);
    batch_ack = ack_v;
    clear     = clr_v;
    apply(1'b0, ack_v, clr_v);
    push(tag);
    @(negedge CLK);
    batch_ack = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic rand_bottle();
    int kind;
    int hlen;
    kind = $urandom_range(0, 9);
    hlen = $urandom_range(D, 10);
    case (kind)
      0:       bottle($urandom_range(1, D - 1), 1'b1, 1'b0, 1'b0, "r_glitch");
      1:       bottle(hlen, 1'b0, 1'b0, 1'b0, "r_en_off");
      2:       bottle(hlen, 1'b1, 1'b1, 1'b0, "r_ack_pulse");
      3:       ctrl(1'b1, 1'b0, "r_ack");
      default: bottle(hlen, 1'b1, 1'b0, 1'b0, "r_bottle");
    endcase
  endtask

  task automatic reset_with_sensor_high();
    @(negedge CLK);
    sealed_in = 1'b1;
    RST       = 1'b1;
    #1;
    check("rst_async_count",   int'(count),       0);
    check("rst_async_done",    int'(batch_done),  0);
    check("rst_async_total",   int'(batch_total), 0);
    check("rst_async_missed",  int'(missed),      0);
    check("rst_async_overrun", int'(overrun),     0);
    check("rst_async_count2",  int'(count2),      0);
    ma = zero_model();
    mb = zero_model();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    for (int i = 1; i < LEN + 8; i++) begin
      @(negedge CLK);
      if (i == D + 1) push("rst_pre");
      if (i == D + 2) begin
        apply(1'b1, 1'b0, 1'b0);
        push("rst_post");
      end
      if (i == D + 10) push("rst_hold");
      sealed_in = (i < D + 12);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got edge %0d expected completion", cyc);
    $fatal(1, "bench timed out");
  end

  initial begin
    RST       = 1'b1;
    sealed_in = 1'b0;
    en        = 1'b1;
    clear     = 1'b0;
    batch_ack = 1'b0;
    ma        = zero_model();
    mb        = zero_model();
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    push("reset_state");

    bottle(3, 1'b1, 1'b0, 1'b0, "glitch3");
    bottle(10, 1'b1, 1'b0, 1'b0, "clean10");

    while (ma.count < 30) rand_bottle();
    reset_with_sensor_high();

    while (ma.done == 0) rand_bottle();

    for (int k = 0; k < 3; k++) bottle($urandom_range(D, 10), 1'b1, 1'b0, 1'b0, "full_miss");
    bottle($urandom_range(D, 10), 1'b1, 1'b1, 1'b0, "ack_with_pulse");

    for (int k = 0; k < 5; k++) bottle($urandom_range(D, 10), 1'b0, 1'b0, 1'b0, "en_low");
    ctrl(1'b1, 1'b0, "ack_in_count");

    while (ma.done == 0) bottle($urandom_range(D, 10), 1'b1, 1'b0, 1'b0, "refill");
    bottle($urandom_range(D, 10), 1'b1, 1'b0, 1'b1, "clear_pulse");
    bottle($urandom_range(D, 10), 1'b1, 1'b0, 1'b0, "after_clear");

    for (int k = 0; k < 7; k++) bottle($urandom_range(D, 10), 1'b1, 1'b0, 1'b0, "narrow_miss");
    for (int k = 0; k < 10; k++) bottle($urandom_range(D, 10), 1'b1, 1'b1, 1'b0, "narrow_batch");
    ctrl(1'b0, 1'b1, "final_clear");

    repeat (4) @(negedge CLK);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
